// File: rtl/pll_reset_sequencer.sv
// pll_reset_sequencer: waits for a stable synchronised PLL lock, then releases
// the domain resets one after another; any lock loss or sw_reset re-asserts them all.
module pll_reset_sequencer #(
    parameter int SYNC_STAGES = 2,
    parameter int LOCK_CYCLES = 1024,
    parameter int NUM_OUTS    = 3,
    parameter int STAGGER     = 16,
    parameter int LOSS_CNT_W  = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  pll_locked,
    input  logic                  sw_reset,
    output logic [NUM_OUTS-1:0]   rst_out_n,
    output logic                  ready,
    output logic [1:0]            state_o,
    output logic [LOSS_CNT_W-1:0] loss_count
);
    localparam int REL  = (NUM_OUTS - 1) * STAGGER;
    localparam int MAXC = (LOCK_CYCLES > REL + 1) ? LOCK_CYCLES : REL + 1;
    localparam int CW   = $clog2(MAXC + 1);

    typedef enum logic [1:0] {WAIT_LOCK = 2'd0, STABLE = 2'd1, RELEASE = 2'd2, RUN = 2'd3} state_t;

    state_t                 state;
    logic [CW-1:0]          cnt;
    logic [SYNC_STAGES-1:0] sync;
    logic                   locked_s;

    assign locked_s = sync[SYNC_STAGES-1];
    assign state_o  = state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= WAIT_LOCK;
            cnt        <= '0;
            sync       <= '0;
            rst_out_n  <= '0;
            ready      <= 1'b0;
            loss_count <= '0;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], pll_locked};
            if (sw_reset) begin
                state     <= WAIT_LOCK;
                cnt       <= '0;
                rst_out_n <= '0;
                ready     <= 1'b0;
            end else begin
                case (state)
                    WAIT_LOCK: begin
                        cnt <= '0;
                        if (locked_s) state <= STABLE;
                    end
                    STABLE: begin
                        if (!locked_s) begin
                            state <= WAIT_LOCK;
                            cnt   <= '0;
                        end else if (cnt == CW'(LOCK_CYCLES - 1)) begin
                            state <= RELEASE;
                            cnt   <= '0;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    default: begin
                        if (!locked_s) begin
                            state     <= WAIT_LOCK;
                            cnt       <= '0;
                            rst_out_n <= '0;
                            ready     <= 1'b0;
                            if (loss_count != '1) loss_count <= loss_count + 1'b1;
                        end else if (state == RELEASE) begin
                            cnt <= cnt + 1'b1;
                            // each bit rises on its own stagger point, so the vector stays thermometer-coded
                            for (int i = 0; i < NUM_OUTS; i++)
                                if (cnt == CW'(i * STAGGER)) rst_out_n[i] <= 1'b1;
                            if (cnt == CW'(REL)) begin
                                state <= RUN;
                                ready <= 1'b1;
                            end
                        end
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_pll_reset_sequencer.sv
// tb_pll_reset_sequencer: table-driven check of lock qualification, staggered
// release, lock loss, sw_reset priority, counter saturation and async reset.
module tb_pll_reset_sequencer;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       pll_locked;
    logic       sw_reset;
    logic [2:0] rst_out_n;
    logic       ready;
    logic [1:0] state_o;
    logic [1:0] loss_count;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic       lk;
        logic       sw;
        int         n;
        logic [2:0] rst;
        logic       rdy;
        logic [1:0] st;
        logic [1:0] loss;
    } vec_t;

    vec_t tbl[$];
    vec_t sb[$];

    pll_reset_sequencer #(
        .SYNC_STAGES(2), .LOCK_CYCLES(8), .NUM_OUTS(3), .STAGGER(4), .LOSS_CNT_W(2)
    ) dut (
        .clk(clk), .rst_n(rst_n), .pll_locked(pll_locked), .sw_reset(sw_reset),
        .rst_out_n(rst_out_n), .ready(ready), .state_o(state_o), .loss_count(loss_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int idx, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s step %0d: got %0h expected %0h", nm, idx, act, exp);
        end
    endtask

    task automatic add(input logic lk, input logic sw, input int n, input logic [2:0] r,
                       input logic rdy, input logic [1:0] st, input logic [1:0] loss);
        vec_t v;
        v.lk = lk; v.sw = sw; v.n = n; v.rst = r; v.rdy = rdy; v.st = st; v.loss = loss;
        tbl.push_back(v);
    endtask

    task automatic apply(input vec_t v, input int idx);
        vec_t e;
        pll_locked = v.lk;
        sw_reset   = v.sw;
        sb.push_back(v);
        repeat (v.n) @(posedge clk);
        #1;
        e = sb.pop_front();
        chk("rst_out_n", idx, {5'd0, rst_out_n}, {5'd0, e.rst});
        chk("ready", idx, {7'd0, ready}, {7'd0, e.rdy});
        chk("state_o", idx, {6'd0, state_o}, {6'd0, e.st});
        chk("loss_count", idx, {6'd0, loss_count}, {6'd0, e.loss});
    endtask

    initial begin
        rst_n = 1'b0; pll_locked = 1'b0; sw_reset = 1'b0;
        // first lock: T0 is two edges after pll_locked rises
        add(0,0,3, 3'b000,0,0,0);
        add(1,0,2, 3'b000,0,0,0);
        add(1,0,1, 3'b000,0,1,0);
        add(1,0,8, 3'b000,0,2,0);
        add(1,0,1, 3'b001,0,2,0);
        add(1,0,3, 3'b001,0,2,0);
        add(1,0,1, 3'b011,0,2,0);
        add(1,0,3, 3'b011,0,2,0);
        add(1,0,1, 3'b111,1,3,0);
        add(1,0,5, 3'b111,1,3,0);
        // lock loss in RUN, then relock
        add(0,0,2, 3'b111,1,3,0);
        add(0,0,1, 3'b000,0,0,1);
        add(1,0,12,3'b001,0,2,1);
        add(1,0,4, 3'b011,0,2,1);
        add(1,0,4, 3'b111,1,3,1);
        // one-cycle sw_reset pulse in RUN
        add(1,1,1, 3'b000,0,0,1);
        add(1,0,9, 3'b000,0,2,1);
        add(1,0,1, 3'b001,0,2,1);
        add(1,0,8, 3'b111,1,3,1);
        // sw_reset coincident with lock loss: no increment
        add(0,0,2, 3'b111,1,3,1);
        add(0,1,1, 3'b000,0,0,1);
        add(1,1,2, 3'b000,0,0,1);
        // lock glitch during STABLE restarts qualification
        add(1,0,1, 3'b000,0,1,1);
        add(1,0,3, 3'b000,0,1,1);
        add(0,0,1, 3'b000,0,1,1);
        add(1,0,1, 3'b000,0,1,1);
        add(1,0,1, 3'b000,0,0,1);
        add(1,0,1, 3'b000,0,1,1);
        add(1,0,8, 3'b000,0,2,1);
        add(1,0,1, 3'b001,0,2,1);
        add(1,0,8, 3'b111,1,3,1);
        // four more losses saturate the 2-bit counter at 3
        for (int k = 0; k < 4; k++) begin
            add(0,0,3, 3'b000,0,0, (k < 1) ? 2'd2 : 2'd3);
            add(1,0,20,3'b111,1,3, (k < 1) ? 2'd2 : 2'd3);
        end
        add(0,0,3, 3'b000,0,0,3);
        add(1,0,16,3'b011,0,2,3);

        repeat (3) @(posedge clk);
        #1;
        chk("reset rst_out_n", -1, {5'd0, rst_out_n}, 8'd0);
        chk("reset ready", -1, {7'd0, ready}, 8'd0);
        chk("reset state_o", -1, {6'd0, state_o}, 8'd0);
        chk("reset loss_count", -1, {6'd0, loss_count}, 8'd0);
        rst_n = 1'b1;

        for (int i = 0; i < tbl.size(); i++) apply(tbl[i], i);

        // async reset between edges while mid-release at 011
        #2 rst_n = 1'b0;
        #1;
        chk("async rst_out_n", -2, {5'd0, rst_out_n}, 8'd0);
        chk("async ready", -2, {7'd0, ready}, 8'd0);
        chk("async state_o", -2, {6'd0, state_o}, 8'd0);
        chk("async loss_count", -2, {6'd0, loss_count}, 8'd0);
        #20;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
